// File: rtl/alu_sequencer.sv
// Sequencer that hands one operation at a time to an external combinational ALU.
// Operands are registered onto SrcA/SrcB/ALUControl on accept, held for SETTLE_CYCLES
// clock cycles, and then ALUResult/ALUFlags are captured into a response register.
// Optional feature: define ALU_SEQ_CHECK_EN to add an internal reference ALU that flags
// mismatching results (rsp_mismatch) and counts them (err_count).
// SETTLE_CYCLES must lie in 1..15 (it loads a 4-bit counter).

module alu_sequencer #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [3:0]       ALUFlags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic             rsp_mismatch,
  output logic [15:0]      err_count
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       capture;
  logic       consume;

  // State and settle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode plus handshake strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = StDrive;
          cnt_d   = SettleInit;
        end
      end
      StDrive: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a zero count can never wedge the FSM.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          req_ready = 1'b1;
          consume   = 1'b1;
          if (req_valid) begin
            state_d = StDrive;
            cnt_d   = SettleInit;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = req_valid & req_ready;

  // ALU operand registers: loaded only on accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SrcA       <= '0;
      SrcB       <= '0;
      ALUControl <= 2'b00;
    end else if (accept) begin
      SrcA       <= req_a;
      SrcB       <= req_b;
      ALUControl <= req_op;
    end
  end

  // Response register: capture at end of settle, clear valid when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= ALUResult;
      rsp_flags  <= ALUFlags;
    end else if (consume) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_result;
  logic             mismatch;

  // Reference ALU on the held operands; add/sub wrap modulo 2^WIDTH.
  always_comb begin
    exp_result = '0;
    unique case (ALUControl)
      2'b00:   exp_result = SrcA + SrcB;
      2'b01:   exp_result = SrcA - SrcB;
      2'b10:   exp_result = SrcA & SrcB;
      2'b11:   exp_result = SrcA | SrcB;
      default: exp_result = '0;
    endcase
  end

  assign mismatch = (ALUResult != exp_result);

  // Mismatch flag travels with rsp_result; error counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mismatch <= 1'b0;
      err_count    <= 16'd0;
    end else if (capture) begin
      rsp_mismatch <= mismatch;
      if (mismatch && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: scoreboard of expected responses pushed on
// accept and popped on response handshake, plus directed stall, reset and settle tests.

module tb_alu_sequencer;

  localparam int unsigned W  = 64;
  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with SETTLE_CYCLES=1
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]   req_op, alu_ctl;
  logic [W-1:0] req_a, req_b, src_a, src_b, alu_res, rsp_result;
  logic [3:0]   alu_flg, rsp_flags;
  // DUT with SETTLE_CYCLES=3
  logic         req_valid3, req_ready3, rsp_valid3;
  logic [1:0]   alu_ctl3;
  logic [W-1:0] src_a3, src_b3, alu_res3, rsp_result3;
  logic [3:0]   alu_flg3, rsp_flags3;
`ifdef ALU_SEQ_CHECK_EN
  logic         mism, mism3;
  logic [15:0]  errc, errc3;
`endif

  logic alu_fault;

  alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .SrcA(src_a), .SrcB(src_b), .ALUControl(alu_ctl),
    .ALUResult(alu_res), .ALUFlags(alu_flg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef ALU_SEQ_CHECK_EN
    , .rsp_mismatch(mism), .err_count(errc)
`endif
  );

  alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .SrcA(src_a3), .SrcB(src_b3), .ALUControl(alu_ctl3),
    .ALUResult(alu_res3), .ALUFlags(alu_flg3),
    .rsp_valid(rsp_valid3), .rsp_ready(1'b1),
    .rsp_result(rsp_result3), .rsp_flags(rsp_flags3)
`ifdef ALU_SEQ_CHECK_EN
    , .rsp_mismatch(mism3), .err_count(errc3)
`endif
  );

  // Bench ALU: returns {N, Z, C, 0, result}.
  function automatic logic [W+3:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    s = '0;
    r = '0;
    c = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = ~s[W]; end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r[W-1], (r == '0), c, 1'b0, r};
  endfunction

  logic [W+3:0] calc1, calc3;
  always_comb begin
    calc1    = alu_calc(src_a, src_b, alu_ctl);
    alu_res  = calc1[W-1:0] + W'(alu_fault);
    alu_flg  = calc1[W+3:W];
    calc3    = alu_calc(src_a3, src_b3, alu_ctl3);
    alu_res3 = calc3[W-1:0];
    alu_flg3 = calc3[W+3:W];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         mism;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  bit           head_seen = 1'b0;
  logic [W+3:0] mon_calc;

  // Monitor: compare response against scoreboard head, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          if (!head_seen) begin
            check_eq("rsp_latency", 64'(cyc), 64'(sb_q[0].acc + int'(S1)));
            head_seen = 1'b1;
          end
          check_eq("rsp_result", rsp_result, sb_q[0].res);
          check_eq("rsp_flags", 64'(rsp_flags), 64'(sb_q[0].flg));
`ifdef ALU_SEQ_CHECK_EN
          check_eq("rsp_mismatch", 64'(mism), 64'(sb_q[0].mism));
`endif
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (req_valid && req_ready) begin
        mon_calc = alu_calc(req_a, req_b, req_op);
        sb_q.push_back('{res: mon_calc[W-1:0] + W'(alu_fault), flg: mon_calc[W+3:W],
                         mism: alu_fault, acc: cyc + 1});
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    check_eq("req_accepted", 64'(acc), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    head_seen = 1'b0;
  endtask

  task automatic op_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                           input logic [W-1:0] res, input string tag);
    int t;
    do_op(a, b, op, t);
    drain();
    check_eq(tag, rsp_result, res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [W-1:0] a3, b3;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    rsp_ready  = 1'b1;
    alu_fault  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = 2'b00;

    // Reset state, checked before any clock edge
    #2;
    check_eq("rst_src_a", src_a, 64'd0);
    check_eq("rst_src_b", src_b, 64'd0);
    check_eq("rst_alu_ctl", 64'(alu_ctl), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_result", rsp_result, 64'd0);
    check_eq("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed operations with known results
    op_expect(64'd105, 64'd215, 2'b00, 64'd320, "add_320");
    op_expect(64'd105, 64'd215, 2'b10, 64'd65, "and_65");
    op_expect(64'd105, 64'd215, 2'b11, 64'd255, "or_255");
    op_expect(64'd105, 64'd105, 2'b01, 64'd0, "sub_zero");
    op_expect({W{1'b1}}, 64'd1, 2'b00, 64'd0, "add_wrap");
    op_expect(64'd1000, 64'd7, 2'b01, 64'd993, "sub_993");

    // Back-to-back random stream with rsp_ready high
    for (int i = 0; i < 6; i++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), t);
    end
    drain();

    // Stall: rsp_ready low for 5 cycles with a pending request
    rsp_ready = 1'b0;
    do_op(64'h1234, 64'h0f0f, 2'b01, t);
    req_valid = 1'b1;
    req_a     = 64'hAAAA;
    req_b     = 64'h5555;
    req_op    = 2'b11;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(rsp_valid), 64'd1);
      check_eq("stall_req_ready", 64'(req_ready), 64'd0);
      check_eq("stall_result", rsp_result, 64'h1234 - 64'h0f0f);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("b2b_src_a", src_a, 64'hAAAA);
    check_eq("b2b_src_b", src_b, 64'h5555);
    check_eq("b2b_alu_ctl", 64'(alu_ctl), 64'd3);
    drain();
    check_eq("b2b_result", rsp_result, 64'hFFFF);

    // Reset pulsed during DRIVE abandons the operation
    do_op(64'd77, 64'd88, 2'b00, t);
    rst_n = 1'b0;
    #1;
    check_eq("rstd_src_a", src_a, 64'd0);
    check_eq("rstd_src_b", src_b, 64'd0);
    check_eq("rstd_alu_ctl", 64'(alu_ctl), 64'd0);
    check_eq("rstd_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rstd_rsp_result", rsp_result, 64'd0);
    check_eq("rstd_rsp_flags", 64'(rsp_flags), 64'd0);
    sb_q.delete();
    head_seen = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstd_no_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    do_op(64'd9, 64'd4, 2'b01, t);
    check_eq("rstd_first_accept", 64'(t), 64'd1);
    drain();
    check_eq("rstd_post_result", rsp_result, 64'd5);

    // SETTLE_CYCLES=3: latency and operand stability
    a3 = 64'hF0F0_1234_5678_9ABC;
    b3 = 64'h0FF0_FFFF_0000_FFFF;
    @(negedge clk);
    check_eq("s3_req_ready", 64'(req_ready3), 64'd1);
    @(posedge clk);
    #1;
    req_valid3 = 1'b1;
    req_a      = a3;
    req_b      = b3;
    req_op     = 2'b10;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    req_a      = {$urandom, $urandom};
    req_b      = {$urandom, $urandom};
    req_op     = 2'b01;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      check_eq("s3_valid", 64'(rsp_valid3), 64'(i == 3));
      check_eq("s3_src_a", src_a3, a3);
      check_eq("s3_src_b", src_b3, b3);
      check_eq("s3_alu_ctl", 64'(alu_ctl3), 64'd2);
      if (i == 3) check_eq("s3_result", rsp_result3, a3 & b3);
      @(posedge clk);
      #1;
    end
`ifdef ALU_SEQ_CHECK_EN
    check_eq("s3_mismatch", 64'(mism3), 64'd0);
    check_eq("s3_err_count", 64'(errc3), 64'd0);

    // Faulty ALU (result+1): every response mismatches
    check_eq("err_count_pre", 64'(errc), 64'd0);
    alu_fault = 1'b1;
    op_expect(64'd10, 64'd20, 2'b00, 64'd31, "fault_add");
    op_expect(64'd50, 64'd20, 2'b01, 64'd31, "fault_sub");
    op_expect(64'd12, 64'd10, 2'b10, 64'd9, "fault_and");
    alu_fault = 1'b0;
    check_eq("err_count", 64'(errc), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
